// File: rtl/fp_sqrt_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_iter_if
// Description : Operand / result bundle for the iterative FP square-root unit.
//               master = issuing side (reservation station / testbench)
//               slave  = fp_sqrt_iter
// Ports       : start, a, rm, tag_in, flush      (master -> slave)
//               busy, done, result, tag_out,
//               exception, inexact, zero_sqrt    (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_sqrt_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 6
);
    localparam int FP_W = 1 + EXP_W + MAN_W;

    logic             start;
    logic [FP_W-1:0]  a;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [FP_W-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             exception;
    logic             inexact;
    logic             zero_sqrt;

    modport master (
        output start, a, rm, tag_in, flush,
        input  busy, done, result, tag_out, exception, inexact, zero_sqrt
    );

    modport slave (
        input  start, a, rm, tag_in, flush,
        output busy, done, result, tag_out, exception, inexact, zero_sqrt
    );
endinterface
`default_nettype wire

// File: rtl/fp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_iter
// Description : Parametrised iterative IEEE-754 square root. Restoring
//               digit recurrence producing BPC root bits per cycle, all five
//               RISC-V rounding modes, subnormal inputs, NV/NX flags,
//               pass-through ROB tag and pipeline flush.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - fp_sqrt_iter_if.slave (start/a/rm/tag_in/flush in,
//                        busy/done/result/tag_out/exception/inexact/
//                        zero_sqrt out)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BPC   = 1,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_sqrt_iter_if.slave      bus
);
    localparam int FP_W   = 1 + EXP_W + MAN_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int ITERS  = (MAN_W + 3 + BPC - 1) / BPC;
    localparam int NB     = ITERS * BPC;          // root bits produced
    localparam int EXTRA  = NB - (MAN_W + 3);     // surplus low root bits (fold into sticky)
    localparam int RAD_W  = 2 * NB;
    localparam int REM_W  = NB + 3;
    localparam int CNT_W  = $clog2(ITERS + 1);
    localparam int LZC_W  = $clog2(MAN_W + 1);
    localparam int SE_W   = EXP_W + LZC_W + 2;    // signed unbiased exponent width

    localparam logic [FP_W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [NB-1:0]   LOW_MASK  = (NB'(1) << EXTRA) - NB'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ITER   = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured operation
    logic [FP_W-1:0]  a_q;
    logic [2:0]       rm_q;
    logic [TAG_W-1:0] tag_q;

    // Recurrence state
    logic [RAD_W-1:0] rad_q;
    logic [REM_W-1:0] rem_q;
    logic [NB-1:0]    root_q;
    logic [CNT_W-1:0] cnt_q;
    logic [EXP_W-1:0] exp_q;
    logic             spec_q;
    logic [FP_W-1:0]  spec_res_q;
    logic             spec_nv_q;
    logic             spec_zero_q;

    // Architected outputs
    logic [FP_W-1:0]  result_q;
    logic [TAG_W-1:0] tag_out_q;
    logic             nv_q;
    logic             nx_q;
    logic             zero_q;

    // FSM strobes
    logic accept, do_unpack, do_iter, do_round;

    // ------------------------------------------------------------------
    // Operand classification and normalisation
    // ------------------------------------------------------------------
    logic                    w_sign;
    logic [EXP_W-1:0]        w_exp_f;
    logic [MAN_W-1:0]        w_frac;
    logic                    w_exp_ones, w_exp_zero, w_frac_zero;
    logic                    w_special;
    logic [FP_W-1:0]         w_spec_res;
    logic                    w_spec_nv, w_spec_zero;
    logic [LZC_W-1:0]        w_lzc;
    logic [MAN_W:0]          w_m_norm;
    logic [MAN_W+1:0]        w_m_adj;
    logic signed [SE_W-1:0]  w_e_unb, w_e_even, w_e_half;
    logic [SE_W-1:0]         w_e_res;

    assign w_sign      = a_q[FP_W-1];
    assign w_exp_f     = a_q[FP_W-2:MAN_W];
    assign w_frac      = a_q[MAN_W-1:0];
    assign w_exp_ones  = &w_exp_f;
    assign w_exp_zero  = ~|w_exp_f;
    assign w_frac_zero = ~|w_frac;

    always_comb begin
        w_special   = 1'b0;
        w_spec_res  = '0;
        w_spec_nv   = 1'b0;
        w_spec_zero = 1'b0;
        if (w_exp_ones && !w_frac_zero) begin
            // NaN: signalling when the quiet bit is clear
            w_special  = 1'b1;
            w_spec_res = CANON_NAN;
            w_spec_nv  = ~w_frac[MAN_W-1];
        end else if (w_exp_zero && w_frac_zero) begin
            w_special   = 1'b1;
            w_spec_res  = a_q;
            w_spec_zero = 1'b1;
        end else if (w_sign) begin
            w_special  = 1'b1;
            w_spec_res = CANON_NAN;
            w_spec_nv  = 1'b1;
        end else if (w_exp_ones) begin
            w_special  = 1'b1;
            w_spec_res = a_q;
        end
    end

    // Leading-zero count of {0,frac}; only meaningful for subnormals
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (w_frac[i]) w_lzc = LZC_W'(MAN_W - i);
        end
    end

    always_comb begin
        w_m_norm = w_exp_zero ? ({1'b0, w_frac} << w_lzc) : {1'b1, w_frac};
        w_e_unb  = w_exp_zero ? (SE_W'(1) - SE_W'(BIAS) - SE_W'(w_lzc))
                              : (SE_W'(w_exp_f) - SE_W'(BIAS));
        // Odd exponent: fold one power of two into the significand
        w_m_adj  = w_e_unb[0] ? {w_m_norm, 1'b0} : {1'b0, w_m_norm};
        w_e_even = w_e_unb - SE_W'(w_e_unb[0]);
        w_e_half = w_e_even >>> 1;
        w_e_res  = w_e_half + SE_W'(BIAS);
    end

    // ------------------------------------------------------------------
    // Restoring recurrence, BPC root bits per cycle
    // ------------------------------------------------------------------
    logic [REM_W-1:0] w_rem_n, w_trial;
    logic [NB-1:0]    w_root_n;
    logic [RAD_W-1:0] w_rad_n;

    always_comb begin
        w_rem_n  = rem_q;
        w_root_n = root_q;
        w_rad_n  = rad_q;
        w_trial  = '0;
        for (int k = 0; k < BPC; k++) begin
            // Bring down the next radicand digit pair
            w_rem_n = {w_rem_n[REM_W-3:0], w_rad_n[RAD_W-1 -: 2]};
            w_rad_n = w_rad_n << 2;
            w_trial = {1'b0, w_root_n, 2'b01};
            if (w_rem_n >= w_trial) begin
                w_rem_n  = w_rem_n - w_trial;
                w_root_n = {w_root_n[NB-2:0], 1'b1};
            end else begin
                w_root_n = {w_root_n[NB-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Rounding: root_q holds MAN_W+1 significand bits, guard, round and
    // EXTRA surplus bits; the root is positive so RDN == RTZ.
    // ------------------------------------------------------------------
    logic [MAN_W:0]   w_mant;
    logic             w_g, w_r, w_st, w_inc, w_nx;
    logic [MAN_W+1:0] w_sum;
    logic [MAN_W-1:0] w_frac_r;
    logic [EXP_W-1:0] w_exp_r;

    always_comb begin
        w_mant = root_q[NB-1 -: MAN_W+1];
        w_g    = root_q[EXTRA+1];
        w_r    = root_q[EXTRA];
        w_st   = (rem_q != '0) || ((root_q & LOW_MASK) != '0);
        w_nx   = w_g | w_r | w_st;
        case (rm_q)
            3'b001:  w_inc = 1'b0;               // RTZ
            3'b010:  w_inc = 1'b0;               // RDN
            3'b011:  w_inc = w_nx;               // RUP
            3'b100:  w_inc = w_g;                // RMM
            default: w_inc = w_g & (w_r | w_st | w_mant[0]); // RNE
        endcase
        w_sum    = {1'b0, w_mant} + (MAN_W+2)'(w_inc);
        w_frac_r = w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
        w_exp_r  = exp_q + EXP_W'(w_sum[MAN_W+1]);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        do_unpack = 1'b0;
        do_iter   = 1'b0;
        do_round  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (bus.flush) state_d = S_IDLE;
                else begin
                    do_unpack = 1'b1;
                    // Specials also take the ROUND slot so the result
                    // register is written from a single place.
                    state_d   = w_special ? S_ROUND : S_ITER;
                end
            end
            S_ITER: begin
                if (bus.flush) state_d = S_IDLE;
                else begin
                    do_iter = 1'b1;
                    if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (bus.flush) state_d = S_IDLE;
                else begin
                    do_round = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            rm_q        <= '0;
            tag_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_nv_q   <= 1'b0;
            spec_zero_q <= 1'b0;
            result_q    <= '0;
            tag_out_q   <= '0;
            nv_q        <= 1'b0;
            nx_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.a;
                rm_q  <= bus.rm;
                tag_q <= bus.tag_in;
            end
            if (do_unpack) begin
                spec_q      <= w_special;
                spec_res_q  <= w_spec_res;
                spec_nv_q   <= w_spec_nv;
                spec_zero_q <= w_spec_zero;
                rad_q       <= {w_m_adj, {(RAD_W-MAN_W-2){1'b0}}};
                rem_q       <= '0;
                root_q      <= '0;
                cnt_q       <= '0;
                exp_q       <= w_e_res[EXP_W-1:0];
            end
            if (do_iter) begin
                rad_q  <= w_rad_n;
                rem_q  <= w_rem_n;
                root_q <= w_root_n;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (do_round) begin
                tag_out_q <= tag_q;
                if (spec_q) begin
                    result_q <= spec_res_q;
                    nv_q     <= spec_nv_q;
                    nx_q     <= 1'b0;
                    zero_q   <= spec_zero_q;
                end else begin
                    result_q <= {1'b0, w_exp_r, w_frac_r};
                    nv_q     <= 1'b0;
                    nx_q     <= w_nx;
                    zero_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.busy      = (state_q == S_UNPACK) || (state_q == S_ITER) || (state_q == S_ROUND);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.tag_out   = tag_out_q;
    assign bus.exception = nv_q;
    assign bus.inexact   = nx_q;
    assign bus.zero_sqrt = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fp_sqrt_iter
// Description : Self-checking bench for fp_sqrt_iter (FP32, BPC=1 main DUT,
//               BPC=2 secondary DUT). Expected results are queued when an
//               operation is issued and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_iter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   gaps     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23), .TAG_W(6)) bus  ();
    fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23), .TAG_W(6)) bus2 ();

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .BPC(1), .TAG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .BPC(2), .TAG_W(6)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic        nv;
        logic        nx;
        logic        zr;
        int          lat;
        int          drv;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {63'd0, bus.done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result",    {32'd0, bus.result},   {32'd0, e.res});
                    check("tag_out",   {58'd0, bus.tag_out},  {58'd0, e.tag});
                    check("nv",        {63'd0, bus.exception}, {63'd0, e.nv});
                    check("nx",        {63'd0, bus.inexact},  {63'd0, e.nx});
                    check("zero_sqrt", {63'd0, bus.zero_sqrt}, {63'd0, e.zr});
                    check("latency",   64'(cyc - e.drv - 1),  64'(e.lat));
                    check("busy_gaps", 64'(gaps),             64'd0);
                    gaps = 0;
                end
            end else if (sb.size() > 0 && cyc > sb[0].drv && !bus.busy) begin
                gaps++;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [2:0] rm, input logic [5:0] tag,
                          input logic [31:0] res, input logic nv, input logic nx,
                          input logic zr, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.a      = a;
        bus.rm     = rm;
        bus.tag_in = tag;
        bus.start  = 1'b1;
        e.res = res; e.tag = tag; e.nv = nv; e.nx = nx; e.zr = zr; e.lat = lat; e.drv = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pending_after_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.flush = 1'b0; bus.a = '0; bus.rm = '0; bus.tag_in = '0;
        bus2.start = 1'b0; bus2.flush = 1'b0; bus2.a = '0; bus2.rm = '0; bus2.tag_in = '0;

        repeat (3) @(negedge clk);
        check("rst_outputs", {32'd0, bus.busy, bus.done, bus.exception, bus.inexact,
                              bus.zero_sqrt, bus.tag_out, 20'd0}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // a, rm, tag, expected result, NV, NX, zero, latency
        run_op(32'h40800000, 3'b000, 6'd5,  32'h40000000, 1'b0, 1'b0, 1'b0, 28);
        run_op(32'h40000000, 3'b000, 6'd1,  32'h3FB504F3, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'h40000000, 3'b001, 6'd2,  32'h3FB504F3, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'h40000000, 3'b011, 6'd3,  32'h3FB504F4, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'h40000000, 3'b010, 6'd6,  32'h3FB504F3, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'h40000000, 3'b100, 6'd7,  32'h3FB504F3, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'hC0800000, 3'b000, 6'd4,  32'h7FC00000, 1'b1, 1'b0, 1'b0, 2);
        run_op(32'h7F800001, 3'b000, 6'd8,  32'h7FC00000, 1'b1, 1'b0, 1'b0, 2);
        run_op(32'h7FC00001, 3'b000, 6'd9,  32'h7FC00000, 1'b0, 1'b0, 1'b0, 2);
        run_op(32'h7F800000, 3'b000, 6'd10, 32'h7F800000, 1'b0, 1'b0, 1'b0, 2);
        run_op(32'hFF800000, 3'b000, 6'd11, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 2);
        run_op(32'h80000000, 3'b000, 6'd12, 32'h80000000, 1'b0, 1'b0, 1'b1, 2);
        run_op(32'h00000001, 3'b000, 6'd13, 32'h1A3504F3, 1'b0, 1'b1, 1'b0, 28);
        run_op(32'h3F000000, 3'b000, 6'd14, 32'h3F3504F3, 1'b0, 1'b1, 1'b0, 28);

        // Flush during ITER: no done, busy drops, previous result held
        @(negedge clk);
        bus.a = 32'h41100000; bus.rm = 3'b000; bus.tag_in = 6'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy",   {63'd0, bus.busy},    64'd0);
        check("flush_result", {32'd0, bus.result},  {32'd0, 32'h3F3504F3});
        check("flush_tag",    {58'd0, bus.tag_out}, {58'd0, 6'd14});
        repeat (40) @(negedge clk);

        // start together with flush is not accepted
        bus.start = 1'b1; bus.flush = 1'b1; bus.tag_in = 6'd21;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("start_flush_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(negedge clk);

        run_op(32'h41100000, 3'b000, 6'd22, 32'h40400000, 1'b0, 1'b0, 1'b0, 28);

        // BPC=2 build
        bus2.a = 32'h40800000; bus2.rm = 3'b000; bus2.tag_in = 6'd5; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        n = 1;
        while (!bus2.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bpc2_latency", 64'(n - 1), 64'd15);
        check("bpc2_result",  {32'd0, bus2.result}, {32'd0, 32'h40000000});
        check("bpc2_tag",     {58'd0, bus2.tag_out}, {58'd0, 6'd5});
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-ITER clears everything at once
        bus.a = 32'h40800000; bus.tag_in = 6'd30; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ctrl",   {32'd0, bus.busy, bus.done, bus.exception, bus.inexact,
                              bus.zero_sqrt, 27'd0}, 64'd0);
        check("arst_result", {32'd0, bus.result},  64'd0);
        check("arst_tag",    {58'd0, bus.tag_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
